// File: rtl/vx_mem_model_pkg.sv
// Shared constants and response type for the memory model.
// Optional write responses are enabled with MEM_MODEL_WRITE_RSP_EN.
package VX_mem_model_pkg;
  localparam int DEF_DATA_WIDTH = 512;
  localparam int DEF_ADDR_WIDTH = 26;
  localparam int DEF_TAG_WIDTH = 48;
  localparam int DEF_DEPTH_LOG2 = 10;
  localparam logic [31:0] RESET_WORD = 32'hdeadbeef;
  localparam logic [DEF_DATA_WIDTH-1:0] RESET_DATA =
    {(DEF_DATA_WIDTH/32){RESET_WORD}};
  localparam logic [DEF_TAG_WIDTH-1:0] RESET_TAG = '0;

  typedef struct packed {
    logic [DEF_DATA_WIDTH-1:0] data;
    logic [DEF_TAG_WIDTH-1:0] tag;
  } mem_model_rsp_t;
endpackage

// File: rtl/vx_mem_bus_if.sv
// Line-granular memory request/response bus.
// Master issues requests, slave returns tagged in-order responses.
interface VX_mem_bus_if #(
  parameter int DATA_WIDTH = 512,
  parameter int ADDR_WIDTH = 26,
  parameter int TAG_WIDTH = 48
) ();
  typedef struct packed {
    logic rw;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0] tag;
  } req_data_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0] tag;
  } rsp_data_t;

  logic req_valid;
  logic req_ready;
  req_data_t req_data;
  logic rsp_valid;
  logic rsp_ready;
  rsp_data_t rsp_data;

  modport master (
    output req_valid, req_data, rsp_ready,
    input req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/vx_mem_model_rsp_fifo.sv
// Response FIFO for the memory model; count feeds credit accounting.
// Push into a full FIFO is accepted only together with a pop.
module VX_mem_model_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter type T = logic
) (
  input logic clk,
  input logic reset,
  input logic push,
  input logic pop,
  input T data_in,
  output T data_out,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  T mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic do_push;
  logic do_pop;

  assign empty = (count == '0);
  assign full = (count == (AW+1)'(DEPTH));
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign data_out = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10: count <= count + CNT_ONE;
        2'b01: count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end
endmodule

// File: rtl/vx_mem_model.sv
// Slave memory model: line array, fixed-latency reads, credit-limited FIFO.
// MEM_MODEL_WRITE_RSP_EN also returns a zero-data response per write.
module vx_mem_model
  import VX_mem_model_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int TAG_WIDTH = DEF_TAG_WIDTH,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int READ_LATENCY = 4,
  parameter int RSP_FIFO_DEPTH = 4
) (
  input logic clk,
  input logic reset,
  VX_mem_bus_if.slave mem_bus_if,
  output logic [31:0] num_writes,
  output logic [31:0] num_reads,
  output logic [31:0] num_oob
);
  localparam int LINES = 1 << DEPTH_LOG2;
  localparam int CW = $clog2(RSP_FIFO_DEPTH);
  localparam logic [DATA_WIDTH-1:0] FILL =
    {(DATA_WIDTH/32){RESET_WORD}};

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0] tag;
  } rsp_t;

  logic [DATA_WIDTH-1:0] mem [LINES];
  logic [LINES-1:0] written;
  logic [READ_LATENCY-1:0] pipe_valid;
  rsp_t pipe_data [READ_LATENCY];
  rsp_t rd_rsp;
  rsp_t rsp_head;
  logic fifo_full;
  logic fifo_empty;
  logic [CW:0] fifo_count;
  logic [31:0] outstanding;
  logic accept;
  logic is_write;
  logic in_range;
  logic issue;
  logic pop;
  logic [DEPTH_LOG2-1:0] line;

  assign accept = mem_bus_if.req_valid && mem_bus_if.req_ready;
  assign is_write = mem_bus_if.req_data.rw;
  assign line = mem_bus_if.req_data.addr[DEPTH_LOG2-1:0];
  assign in_range = (mem_bus_if.req_data.addr >> DEPTH_LOG2) == '0;

`ifdef MEM_MODEL_WRITE_RSP_EN
  assign issue = accept;
`else
  assign issue = accept && !is_write;
`endif

  // Line is sampled here, so later writes never touch an in-flight read.
  always_comb begin
    rd_rsp.tag = mem_bus_if.req_data.tag;
    rd_rsp.data = FILL;
    if (is_write) rd_rsp.data = '0;
    else if (in_range && written[line]) rd_rsp.data = mem[line];
  end

  always_comb begin
    outstanding = 32'(fifo_count);
    for (int i = 0; i < READ_LATENCY; i++)
      outstanding += 32'(pipe_valid[i]);
  end

  assign mem_bus_if.req_ready =
    !fifo_full && (outstanding < 32'(RSP_FIFO_DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pipe_valid <= '0;
    else pipe_valid <= READ_LATENCY'({pipe_valid, issue});
  end

  always_ff @(posedge clk) begin
    for (int i = READ_LATENCY - 1; i > 0; i--)
      pipe_data[i] <= pipe_data[i-1];
    pipe_data[0] <= rd_rsp;
  end

  always_ff @(posedge clk) begin
    if (accept && is_write && in_range)
      mem[line] <= mem_bus_if.req_data.data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) written <= '0;
    else if (accept && is_write && in_range) written[line] <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num_writes <= '0;
      num_reads <= '0;
      num_oob <= '0;
    end else if (accept) begin
      if (is_write) num_writes <= num_writes + 32'd1;
      else num_reads <= num_reads + 32'd1;
      if (!in_range) num_oob <= num_oob + 32'd1;
    end
  end

  assign pop = mem_bus_if.rsp_valid && mem_bus_if.rsp_ready;

  VX_mem_model_rsp_fifo #(
    .DEPTH(RSP_FIFO_DEPTH),
    .T(rsp_t)
  ) rsp_fifo (
    .clk(clk),
    .reset(reset),
    .push(pipe_valid[READ_LATENCY-1]),
    .pop(pop),
    .data_in(pipe_data[READ_LATENCY-1]),
    .data_out(rsp_head),
    .full(fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  assign mem_bus_if.rsp_valid = !fifo_empty;
  assign mem_bus_if.rsp_data = fifo_empty ? '0 : rsp_head;
endmodule

// File: tb/tb_vx_mem_model.sv
// Bench for vx_mem_model: directed cases plus randomized traffic
// checked every cycle against a queue-based reference model.
module tb_vx_mem_model;
  import VX_mem_model_pkg::*;

  localparam int L = 4;
  localparam int FD = 4;
  localparam int LINES = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] num_writes;
  logic [31:0] num_reads;
  logic [31:0] num_oob;
  int n_asserts = 0;
  int n_fail = 0;

  VX_mem_bus_if #(
    .DATA_WIDTH(512), .ADDR_WIDTH(26), .TAG_WIDTH(48)
  ) bus ();

  vx_mem_model #(
    .DATA_WIDTH(512), .ADDR_WIDTH(26), .TAG_WIDTH(48),
    .DEPTH_LOG2(10), .READ_LATENCY(L), .RSP_FIFO_DEPTH(FD)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .mem_bus_if(bus),
    .num_writes(num_writes),
    .num_reads(num_reads),
    .num_oob(num_oob)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] data;
    logic [47:0] tag;
    int due;
  } exp_t;

  exp_t q[$];
  logic [511:0] mem_m [int];
  logic [31:0] ew = '0;
  logic [31:0] er = '0;
  logic [31:0] eo = '0;
  int cyc = 0;
  logic [47:0] seen[$];

  task automatic chk(input string nm, input logic [511:0] act,
                     input logic [511:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: a response is due L+1 negedges after its accept.
  always @(negedge clk) begin
    logic exp_v;
    exp_t e;
    logic [25:0] a;
    if (!rst_n) begin
      chk("rst_req_ready", bus.req_ready, 1'b1);
      chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
      chk("rst_rsp_data", bus.rsp_data.data, '0);
      chk("rst_rsp_tag", bus.rsp_data.tag, '0);
      chk("rst_cnt", {num_writes, num_reads, num_oob}, '0);
      q.delete();
      mem_m.delete();
      ew = '0;
      er = '0;
      eo = '0;
    end else begin
      exp_v = (q.size() > 0) && (q[0].due <= cyc);
      chk("req_ready", bus.req_ready, q.size() < FD);
      chk("rsp_valid", bus.rsp_valid, exp_v);
      if (exp_v) begin
        chk("rsp_data", bus.rsp_data.data, q[0].data);
        chk("rsp_tag", bus.rsp_data.tag, q[0].tag);
      end
      chk("num_writes", num_writes, ew);
      chk("num_reads", num_reads, er);
      chk("num_oob", num_oob, eo);
      if (bus.rsp_valid && bus.rsp_ready) begin
        seen.push_back(bus.rsp_data.tag);
        if (q.size() > 0) void'(q.pop_front());
      end
      if (bus.req_valid && bus.req_ready) begin
        a = bus.req_data.addr;
        if (bus.req_data.rw) begin
          ew++;
          if (a < LINES) mem_m[int'(a)] = bus.req_data.data;
          else eo++;
`ifdef MEM_MODEL_WRITE_RSP_EN
          q.push_back('{data: '0, tag: bus.req_data.tag, due: cyc + 1 + L});
`endif
        end else begin
          er++;
          if (a >= LINES) eo++;
          e.data = (a < LINES && mem_m.exists(int'(a))) ?
                   mem_m[int'(a)] : RESET_DATA;
          e.tag = bus.req_data.tag;
          e.due = cyc + 1 + L;
          q.push_back(e);
        end
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic rw, input logic [25:0] addr,
                     input logic [511:0] data, input logic [47:0] tag);
    bit ok;
    ok = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_data.rw = rw;
    bus.req_data.addr = addr;
    bus.req_data.data = data;
    bus.req_data.tag = tag;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = bus.req_ready;
      tick();
    end
    bus.req_valid = 1'b0;
    if (!ok) chk("req_accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_rsp(output logic [511:0] d, output logic [47:0] t,
                          output int lat);
    d = '0;
    t = '0;
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      if (bus.rsp_valid) begin
        d = bus.rsp_data.data;
        t = bus.rsp_data.tag;
        lat = i;
        tick();
        return;
      end
      tick();
    end
    chk("rsp_timeout", 1'b0, 1'b1);
  endtask

  function automatic logic [511:0] rnd_line();
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [511:0] dead;
    logic [511:0] d;
    logic [47:0] t;
    int lat;
    int n_acc;
    int cnt;
    bit acc;
    dead = {16{32'hdeadbeef}};
    bus.req_valid = 1'b0;
    bus.req_data = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) tick();
    chk("reset_ready", bus.req_ready, 1'b1);
    chk("reset_valid", bus.rsp_valid, 1'b0);
    rst_n = 1'b1;
    tick();

    req(1'b0, 26'h4, '0, 48'h7);
    wait_rsp(d, t, lat);
    chk("t1_latency", lat, 5);
    chk("t1_data", d, dead);
    chk("t1_tag", t, 48'h7);
    chk("t1_num_reads", num_reads, 32'd1);

    req(1'b1, 26'h4, 512'h2000f133, 48'h0);
    req(1'b0, 26'h4, '0, 48'h1);
`ifdef MEM_MODEL_WRITE_RSP_EN
    wait_rsp(d, t, lat);
    chk("t2_wrsp_tag", t, 48'h0);
`endif
    wait_rsp(d, t, lat);
    chk("t2_data", d, 512'h2000f133);
    chk("t2_tag", t, 48'h1);
    chk("t2_num_writes", num_writes, 32'd1);

    bus.rsp_ready = 1'b0;
    seen.delete();
    n_acc = 0;
    bus.req_valid = 1'b1;
    bus.req_data.rw = 1'b0;
    bus.req_data.addr = 26'h8;
    bus.req_data.tag = 48'h0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      acc = bus.req_valid && bus.req_ready;
      tick();
      if (acc) begin
        n_acc++;
        bus.req_data.tag = 48'(n_acc);
        bus.req_data.addr = 26'(8 + n_acc);
        if (n_acc == 8) bus.req_valid = 1'b0;
      end
    end
    chk("t3_stall_accepts", n_acc, 4);
    chk("t3_stall_ready", bus.req_ready, 1'b0);
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 60 && (n_acc < 8 || seen.size() < 8); c++) begin
      @(negedge clk);
      acc = bus.req_valid && bus.req_ready;
      tick();
      if (acc) begin
        n_acc++;
        bus.req_data.tag = 48'(n_acc);
        bus.req_data.addr = 26'(8 + n_acc);
        if (n_acc == 8) bus.req_valid = 1'b0;
      end
    end
    chk("t3_accepts", n_acc, 8);
    chk("t3_rsp_count", seen.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < seen.size()) chk($sformatf("t3_order%0d", i), seen[i], i);

    req(1'b1, 26'h0, 512'h55, 48'h3);
    req(1'b1, 26'h400, 512'haa, 48'h4);
    req(1'b0, 26'h400, '0, 48'h5);
`ifdef MEM_MODEL_WRITE_RSP_EN
    wait_rsp(d, t, lat);
    wait_rsp(d, t, lat);
`endif
    wait_rsp(d, t, lat);
    chk("t4_oob_data", d, dead);
    chk("t4_oob_tag", t, 48'h5);
    req(1'b0, 26'h0, '0, 48'h6);
    wait_rsp(d, t, lat);
    chk("t4_line0", d, 512'h55);
    chk("t4_num_oob", num_oob, 32'd2);

    req(1'b0, 26'h5, '0, 48'h3);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("t5_rst_cnt", {num_writes, num_reads, num_oob}, '0);
    chk("t5_rst_ready", bus.req_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.rsp_valid) cnt++;
      tick();
    end
    chk("t5_dropped", cnt, 0);
    chk("t5_num_reads", num_reads, 32'd0);

    req(1'b1, 26'h6, rnd_line(), 48'h9);
`ifdef MEM_MODEL_WRITE_RSP_EN
    wait_rsp(d, t, lat);
    chk("t6_wrsp_tag", t, 48'h9);
    chk("t6_wrsp_data", d, '0);
    chk("t6_wrsp_lat", lat, 5);
`else
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.rsp_valid) cnt++;
      tick();
    end
    chk("t6_no_wrsp", cnt, 0);
`endif

    for (int c = 0; c < 800; c++) begin
      bus.req_valid = ($urandom_range(0, 9) < 7);
      bus.req_data.rw = $urandom_range(0, 2) == 0;
      bus.req_data.addr = ($urandom_range(0, 4) == 0) ?
        26'(26'h3f8 + $urandom_range(0, 15)) : 26'($urandom_range(0, 15));
      bus.req_data.data = rnd_line();
      bus.req_data.tag = {$urandom, 16'($urandom)};
      bus.rsp_ready = ($urandom_range(0, 9) < 6);
      rst_n = ($urandom_range(0, 249) != 0);
      tick();
    end
    rst_n = 1'b1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (20) tick();
    chk("drain_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asserts, n_fail);
    $finish;
  end
endmodule
